// File: rtl/apb_slave_responder.sv
// rtl/apb_slave_responder.sv - APB completer with word register file and programmable wait states.
// Optional error response on missed transfers: define APB_SLVERR_EN.
module apb_slave_responder #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_CYCLES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET_n,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);
    localparam int                IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(NUM_REGS * 4);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              hit_q, hit_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic [ADDR_W-1:0] offset;
    logic              hit_now;
    logic [IDX_W-1:0]  idx_now;

    always_comb begin
        offset   = PADDR - BASE_ADDR;
        hit_now  = (offset < SPAN) && (PADDR[1:0] == 2'b00);
        idx_now  = offset[2 +: IDX_W];
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        hit_d    = hit_q;
        idx_d    = idx_q;
        prdata_d = prdata_q;
        regs_d   = regs_q;
        case (state_q)
            IDLE: begin
                // PENABLE high without a setup phase is a protocol violation and is ignored
                if (PSELx && !PENABLE) begin
                    state_d = ACCESS;
                    wr_d    = PWRITE;
                    hit_d   = hit_now;
                    idx_d   = idx_now;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (!PWRITE) begin
                        prdata_d = hit_now ? regs_q[idx_now] : '0;
                    end
                end
            end
            ACCESS: begin
                if (!PSELx) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (PENABLE) begin
                    if (wr_q && hit_q) begin
                        regs_d[idx_q] = PWDATA;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET_n) begin
        if (!HRESET_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            wr_q     <= 1'b0;
            hit_q    <= 1'b0;
            idx_q    <= '0;
            prdata_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            hit_q    <= hit_d;
            idx_q    <= idx_d;
            prdata_q <= prdata_d;
            regs_q   <= regs_d;
        end
    end

    // Ready is decoded purely from registered state so it carries no path from the bus inputs
    assign PREADY = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign PRDATA = prdata_q;

`ifdef APB_SLVERR_EN
    assign PSLVERR = PREADY && !hit_q;
`else
    assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_responder.sv
// tb/tb_apb_slave_responder.sv - scoreboard bench for apb_slave_responder (zero-wait and 3-wait instances).
module tb_apb_slave_responder;
`ifdef APB_SLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        psel0, psel1, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
        logic        err;
        int          waits;
    } exp_t;
    exp_t sb_q[$];

    apb_slave_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .HCLK(clk), .HRESET_n(rst_n), .PSELx(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb_slave_responder #(.WAIT_CYCLES(3)) u_dut1 (
        .HCLK(clk), .HRESET_n(rst_n), .PSELx(psel1), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counts PREADY-low access cycles and pops one expectation per completion
    int   wcnt = 0;
    exp_t e;
    logic act_v, rdy_v, err_v;
    logic [31:0] rd_v;
    always @(negedge clk) begin
        act_v = 1'b0; rdy_v = 1'b0; err_v = 1'b0; rd_v = '0;
        if (psel0 && penable) begin
            act_v = 1'b1; rdy_v = pready0; rd_v = prdata0; err_v = pslverr0;
        end else if (psel1 && penable) begin
            act_v = 1'b1; rdy_v = pready1; rd_v = prdata1; err_v = pslverr1;
        end
        if (!act_v) begin
            wcnt = 0;
        end else if (!rdy_v) begin
            wcnt++;
        end else begin
            if (sb_q.size() == 0) begin
                check("unexpected_completion", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("wait_cycles", 32'(wcnt), 32'(e.waits));
                if (e.is_rd) check("prdata", rd_v, e.data);
                check("pslverr", {31'd0, err_v}, {31'd0, e.err});
            end
            wcnt = 0;
        end
    end

    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit miss);
        exp_t x;
        int   n;
        x.is_rd = !wr;
        x.data  = exp_rd;
        x.err   = ERR_EN && miss;
        x.waits = (d != 0) ? 3 : 0;
        sb_q.push_back(x);
        if (d != 0) psel1 = 1'b1; else psel0 = 1'b1;
        pwrite = wr; paddr = a; pwdata = wd; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if ((d != 0) ? pready1 : pready0) break;
            n++;
            if (n > 40) begin
                check("pready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        penable = 1'b0; psel0 = 1'b0; psel1 = 1'b0;
    endtask

    task automatic idle(input int n);
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    time t0;

    initial begin
        rst_n = 1'b0; psel0 = 0; psel1 = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready0", {31'd0, pready0}, 32'd0);
        check("rst_prdata0", prdata0, 32'd0);
        check("rst_pslverr0", {31'd0, pslverr0}, 32'd0);
        check("rst_pready1", {31'd0, pready1}, 32'd0);
        check("rst_prdata1", prdata1, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_pready0", {31'd0, pready0}, 32'd0);

        for (int i = 0; i < 16; i++) xfer(0, 1'b0, 32'(i * 4), '0, 32'd0, 1'b0);
        idle(1);

        t0 = $time;
        xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, '0, 1'b0);
        xfer(0, 1'b0, 32'h08, '0, 32'hDEADBEEF, 1'b0);
        check("zero_wait_cycles", 32'(($time - t0) / 10), 32'd4);
        idle(1);

        xfer(1, 1'b1, 32'h3C, 32'hC0FFEE00, '0, 1'b0);
        xfer(1, 1'b0, 32'h3C, '0, 32'hC0FFEE00, 1'b0);
        idle(1);

        xfer(0, 1'b1, 32'h04, 32'h11111111, '0, 1'b0);
        xfer(0, 1'b0, 32'h04, '0, 32'h11111111, 1'b0);
        xfer(0, 1'b1, 32'h3C, 32'h22222222, '0, 1'b0);
        xfer(0, 1'b0, 32'h3C, '0, 32'h22222222, 1'b0);
        idle(1);

        // Abort a 3-wait write in its second wait cycle
        xfer(1, 1'b1, 32'h10, 32'h0BADF00D, '0, 1'b0);
        psel1 = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hAAAA5555; penable = 1'b0;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1; psel1 = 1'b0; penable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("abort_pready1_low", {31'd0, pready1}, 32'd0);
        end
        xfer(1, 1'b0, 32'h10, '0, 32'h0BADF00D, 1'b0);
        idle(1);

        // PENABLE without setup is ignored
        psel0 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h08;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_setup_pready0", {31'd0, pready0}, 32'd0);
        end
        idle(1);

        // Asynchronous reset in the middle of an access cycle
        psel0 = 1'b1; pwrite = 1'b0; paddr = 32'h08; penable = 1'b0;
        @(posedge clk); #1; penable = 1'b1;
        check("pre_rst_pready0", {31'd0, pready0}, 32'd1);
        check("pre_rst_prdata0", prdata0, 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pready0", {31'd0, pready0}, 32'd0);
        check("async_rst_prdata0", prdata0, 32'd0);
        check("async_rst_pslverr0", {31'd0, pslverr0}, 32'd0);
        psel0 = 1'b0; penable = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h08, '0, 32'd0, 1'b0);
        xfer(1, 1'b0, 32'h3C, '0, 32'd0, 1'b0);
        idle(1);

        // Miss handling: out of range and misaligned
        xfer(0, 1'b1, 32'h00, 32'h5A5A5A5A, '0, 1'b0);
        xfer(0, 1'b1, 32'h40, 32'h12345678, '0, 1'b1);
        xfer(0, 1'b1, 32'h02, 32'h12345678, '0, 1'b1);
        xfer(0, 1'b0, 32'h40, '0, 32'd0, 1'b1);
        xfer(0, 1'b0, 32'h02, '0, 32'd0, 1'b1);
        xfer(0, 1'b0, 32'h00, '0, 32'h5A5A5A5A, 1'b0);
        xfer(0, 1'b0, 32'h04, '0, 32'd0, 1'b0);
        xfer(1, 1'b0, 32'h40, '0, 32'd0, 1'b1);
        idle(3);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_slave_responder.md
Name: apb_slave_responder

Overview:
- APB completer (slave) model at the far end of the AHB-to-APB bridge. It responds to the bridge's PSELx/PENABLE/PWRITE/PADDR/PWDATA with PRDATA and PREADY.
- Contains a word-addressed register file and a programmable wait-state generator.
- Used as the APB-side memory behind the bridge in bench and integration builds, so bridge traffic can be checked end to end.

Parameters:
- ADDR_W, 32, PADDR width.
- DATA_W, 32, PWDATA/PRDATA width.
- NUM_REGS, 16, number of DATA_W-wide registers; power of two, minimum 2.
- BASE_ADDR, 32'h0000_0000, byte address of register 0; aligned to NUM_REGS*4.
- WAIT_CYCLES, 0, number of PREADY-low access cycles per transfer; range 0..15.

Ports:
- HCLK  in  1  clock; all logic on posedge.
- HRESET_n  in  1  asynchronous active-low reset.
- PSELx  in  1  slave select from bridge.
- PENABLE  in  1  access-phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data; valid while PREADY=1 on a read.
- PREADY  out  1  transfer-complete indication.
- PSLVERR  out  1  error response; present only with APB_SLVERR_EN, otherwise tied 0.

Behaviour:
- Interface: one clock, HCLK. Reset HRESET_n is asynchronous, active-low.
- Reset values: state=IDLE, wait counter=0, all registers=0, PRDATA=0, PREADY=0, PSLVERR=0.
- Reset asserted mid-transfer: abort immediately, no write commit, outputs return to reset values.
- Decode: offset = PADDR - BASE_ADDR.
  - hit = (offset < NUM_REGS*4) and (PADDR[1:0]==0).
  - Index = offset[2 +: log2(NUM_REGS)].
- FSM has 2 states, IDLE and ACCESS.
  - IDLE: on a posedge with PSELx=1 and PENABLE=0 (setup phase):
    - latch PWRITE, index and hit;
    - load the wait counter with WAIT_CYCLES;
    - on a read, load PRDATA with reg[index] (0 if not hit);
    - go to ACCESS.
  - IDLE: PENABLE=1 with no preceding setup is ignored; stay in IDLE, PREADY=0.
  - ACCESS, counter != 0: PREADY=0; decrement the counter each cycle.
  - ACCESS, counter == 0: PREADY=1 (decoded from registered state and counter, no input path).
  - ACCESS completes on the posedge where PSELx=1, PENABLE=1 and PREADY=1.
    - A write with hit commits reg[index] <= PWDATA at that edge.
    - Then go to IDLE.
  - ACCESS: PSELx=0 at any posedge aborts the transfer. Go to IDLE with no write and PREADY=0.
- Latency:
  - Setup at cycle T0; PREADY rises in cycle T1+WAIT_CYCLES; transfer completes at the end of that cycle.
  - A back-to-back setup is accepted in the cycle after completion, giving a sustained 2+WAIT_CYCLES cycles per transfer.
- PREADY=0 in IDLE. PRDATA holds its last value outside read access.
- PWDATA is sampled only at the commit edge. PADDR/PWRITE changes during ACCESS are ignored (latched at setup).
- A read from an index written by the immediately preceding transfer returns the new value, because the commit precedes the next setup edge.
- Miss (out of range or misaligned) without the feature: write dropped, read returns 0, normal PREADY timing.

Optional Feature:
- Macro: APB_SLVERR_EN.
- Defined:
  - PSLVERR is driven high together with PREADY in the completing cycle of a missed transfer, and is 0 otherwise.
  - A missed write is dropped; a missed read returns PRDATA=0.
  - Reset value of PSLVERR is 0.
- Undefined: PSLVERR is a constant 0 and no error logic is instantiated.

Test Plan:
- Reset then idle: hold HRESET_n=0 for 3 cycles, then release with PSELx=0 -> PREADY=0, PRDATA=0, PSLVERR=0; a read of every index returns 0.
- Zero-wait write/read (WAIT_CYCLES=0): write 0xDEADBEEF to 0x0000_0008, then read 0x0000_0008 -> PREADY=1 in the first access cycle of each transfer; PRDATA=0xDEADBEEF; 2 cycles per transfer.
- Wait states (WAIT_CYCLES=3): read of 0x0000_003C -> PREADY low for 3 access cycles and high on the 4th; PRDATA stable and correct when PREADY=1.
- Back-to-back transfers: write 0x1111_1111 to 0x04, then immediately read 0x04, then write 0x2222_2222 to 0x3C with no idle between -> read returns 0x1111_1111; reg[15]=0x2222_2222.
- Abort and protocol violation:
  - PSELx dropped in the 2nd of 3 wait cycles of a write of 0xAAAA_5555 to 0x10 -> reg[4] unchanged, FSM back to IDLE.
  - PENABLE=1 without setup -> no response.
  - HRESET_n pulsed low mid-access -> all outputs 0 asynchronously.
- Miss handling: write 0x1234_5678 to 0x0000_0040 (out of range) and to 0x0000_0002 (misaligned), then read the same addresses.
  - Writes do not alter any register; reads return 0.
  - With APB_SLVERR_EN: PSLVERR=1 exactly in the PREADY=1 cycle of all four transfers.
  - Without it: PSLVERR=0 throughout.
